// File: rtl/patgen_seq_pkg.sv
// Shared types and constants for the pattern-generator scan sequencer:
// FSM states, generator register addresses and table byte indices.
package patgen_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_GAP  = 3'd4
    } seq_state_e;

    // Generator configuration register addresses
    localparam logic [3:0] PG_ADDR_NUMPULSES = 4'd7;
    localparam logic [3:0] PG_ADDR_PERIODE   = 4'd8;
    localparam logic [3:0] PG_ADDR_RUNLEN_HI = 4'd10;
    localparam logic [3:0] PG_ADDR_RUNLEN_LO = 4'd11;
    localparam logic [3:0] PG_ADDR_IDELAY_HI = 4'd12;
    localparam logic [3:0] PG_ADDR_IDELAY_LO = 4'd13;
    localparam logic [3:0] PG_ADDR_CLKFAC_HI = 4'd14;
    localparam logic [3:0] PG_ADDR_CLKFAC_LO = 4'd15;

    // Byte positions within one table entry
    localparam logic [2:0] TB_NUMPULSES = 3'd0;
    localparam logic [2:0] TB_PERIODE   = 3'd1;
    localparam logic [2:0] TB_RUNLEN_HI = 3'd2;
    localparam logic [2:0] TB_RUNLEN_LO = 3'd3;
    localparam logic [2:0] TB_IDELAY_HI = 3'd4;
    localparam logic [2:0] TB_IDELAY_LO = 3'd5;
    localparam logic [2:0] TB_CLKFAC_HI = 3'd6;
    localparam logic [2:0] TB_CLKFAC_LO = 3'd7;

    localparam int unsigned ENTRY_BYTES = 8;

    function automatic logic [3:0] pg_addr_of(input logic [2:0] b);
        logic [3:0] a;
        unique case (b)
            TB_NUMPULSES: a = PG_ADDR_NUMPULSES;
            TB_PERIODE:   a = PG_ADDR_PERIODE;
            TB_RUNLEN_HI: a = PG_ADDR_RUNLEN_HI;
            TB_RUNLEN_LO: a = PG_ADDR_RUNLEN_LO;
            TB_IDELAY_HI: a = PG_ADDR_IDELAY_HI;
            TB_IDELAY_LO: a = PG_ADDR_IDELAY_LO;
            TB_CLKFAC_HI: a = PG_ADDR_CLKFAC_HI;
            default:      a = PG_ADDR_CLKFAC_LO;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/patgen_seq_table.sv
// Pulse-set configuration table: NUM_ENTRIES x 8 bytes, synchronous write,
// asynchronous read. Contents are intentionally not reset.
module patgen_seq_table #(
    parameter int unsigned NUM_ENTRIES = 8
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(NUM_ENTRIES)-1:0] wr_entry,
    input  logic [2:0]                     wr_byte,
    input  logic [7:0]                     wr_data,
    input  logic [$clog2(NUM_ENTRIES)-1:0] rd_entry,
    input  logic [2:0]                     rd_byte,
    output logic [7:0]                     rd_data_c
);

    localparam int unsigned EW    = $clog2(NUM_ENTRIES);
    localparam int unsigned DEPTH = NUM_ENTRIES * 8;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[{wr_entry, wr_byte}] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[{rd_entry, rd_byte}];

endmodule

// File: rtl/patgen_scan_sequencer.sv
// Steps a pulse pattern generator through a table of configurations: load 8
// registers, arm via pg_rst, wait for done or timeout, dwell, next entry.
// Optional PATSEQ_STEP_TIMESTAMP_EN adds last_step_cycles (RUN duration).
module patgen_scan_sequencer #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned RST_CYCLES  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tbl_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0] tbl_entry,
    input  logic [2:0]                     tbl_byte,
    input  logic [7:0]                     tbl_din,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           loop,
    input  logic [$clog2(NUM_ENTRIES):0]   num_steps,
    input  logic [15:0]                    gap_cycles,
    input  logic [31:0]                    timeout,
    input  logic                           pause,
    input  logic                           pg_done,
    output logic                           pg_write,
    output logic [3:0]                     pg_addr,
    output logic [7:0]                     pg_din,
    output logic                           pg_rst,
    output logic                           pg_suspend,
    output logic                           busy,
    output logic                           seq_done,
    output logic                           seq_err,
    output logic [$clog2(NUM_ENTRIES)-1:0] step
`ifdef PATSEQ_STEP_TIMESTAMP_EN
    ,
    output logic [31:0]                    last_step_cycles
`endif
);

    import patgen_seq_pkg::*;

    localparam int unsigned SW = $clog2(NUM_ENTRIES);
    localparam int unsigned AW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_e    state_q, state_d;
    logic [2:0]    byte_q, byte_d;
    logic [AW-1:0] arm_q, arm_d;
    logic [15:0]   gap_q, gap_d;
    logic [31:0]   run_q, run_d;
    logic [SW-1:0] step_q, step_d;
    logic          seq_done_q, seq_done_d;
    logic          seq_err_q, seq_err_d;

    logic          pg_write_q, pg_write_d;
    logic [3:0]    pg_addr_q, pg_addr_d;
    logic [7:0]    pg_din_q, pg_din_d;
    logic          pg_rst_q, pg_rst_d;
    logic          busy_q, busy_d;

    logic [7:0]    tbl_rd_c;
    logic [SW:0]   num_eff_c;
    logic          last_step_c;
    logic          timeout_hit_c;
    logic          gap_end_c;

    patgen_seq_table #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_table (
        .clk       (clk),
        .we        (tbl_we),
        .wr_entry  (tbl_entry),
        .wr_byte   (tbl_byte),
        .wr_data   (tbl_din),
        .rd_entry  (step_d),
        .rd_byte   (byte_d),
        .rd_data_c (tbl_rd_c)
    );

    // Step count clamped into 1..NUM_ENTRIES
    always_comb begin
        num_eff_c = num_steps;
        if (num_steps == '0) begin
            num_eff_c = (SW+1)'(1);
        end else if (num_steps > (SW+1)'(NUM_ENTRIES)) begin
            num_eff_c = (SW+1)'(NUM_ENTRIES);
        end
    end

    assign last_step_c   = ((SW+1)'(step_q) + (SW+1)'(1)) == num_eff_c;
    assign timeout_hit_c = (timeout != 32'd0) && (run_q == (timeout - 32'd1));
    assign gap_end_c     = (17'(gap_q) + 17'd1) >= 17'(gap_cycles);

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        arm_d      = arm_q;
        gap_d      = gap_q;
        run_d      = run_q;
        step_d     = step_q;
        seq_done_d = seq_done_q;
        seq_err_d  = seq_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    step_d     = '0;
                    byte_d     = '0;
                    seq_done_d = 1'b0;
                    seq_err_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (byte_q == 3'd7) begin
                    state_d = ST_ARM;
                    arm_d   = '0;
                end else begin
                    byte_d = byte_q + 3'd1;
                end
            end
            ST_ARM: begin
                if (arm_q == AW'(RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    run_d   = '0;
                end else begin
                    arm_d = arm_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    // A timeout is flagged but otherwise treated like done
                    if (pg_done || timeout_hit_c) begin
                        if (!pg_done) begin
                            seq_err_d = 1'b1;
                        end
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else if (run_q != '1) begin
                        run_d = run_q + 32'd1;
                    end
                end
            end
            ST_GAP: begin
                if (!pause) begin
                    if (gap_end_c) begin
                        byte_d = '0;
                        if (!last_step_c) begin
                            step_d  = step_q + SW'(1);
                            state_d = ST_LOAD;
                        end else if (loop) begin
                            step_d  = '0;
                            state_d = ST_LOAD;
                        end else begin
                            seq_done_d = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            seq_done_d = seq_done_q;
            seq_err_d  = seq_err_q;
        end
    end

    // Output registers follow the next state so they line up with state_q
    always_comb begin
        pg_write_d = 1'b0;
        pg_addr_d  = '0;
        pg_din_d   = '0;
        if (state_d == ST_LOAD) begin
            pg_write_d = 1'b1;
            pg_addr_d  = pg_addr_of(byte_d);
            pg_din_d   = tbl_rd_c;
        end
        pg_rst_d = (state_d != ST_RUN);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_q     <= '0;
            arm_q      <= '0;
            gap_q      <= '0;
            run_q      <= '0;
            step_q     <= '0;
            seq_done_q <= 1'b0;
            seq_err_q  <= 1'b0;
            pg_write_q <= 1'b0;
            pg_addr_q  <= '0;
            pg_din_q   <= '0;
            pg_rst_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            arm_q      <= arm_d;
            gap_q      <= gap_d;
            run_q      <= run_d;
            step_q     <= step_d;
            seq_done_q <= seq_done_d;
            seq_err_q  <= seq_err_d;
            pg_write_q <= pg_write_d;
            pg_addr_q  <= pg_addr_d;
            pg_din_q   <= pg_din_d;
            pg_rst_q   <= pg_rst_d;
            busy_q     <= busy_d;
        end
    end

    assign pg_write   = pg_write_q;
    assign pg_addr    = pg_addr_q;
    assign pg_din     = pg_din_q;
    assign pg_rst     = pg_rst_q;
    assign pg_suspend = pause;
    assign busy       = busy_q;
    assign seq_done   = seq_done_q;
    assign seq_err    = seq_err_q;
    assign step       = step_q;

`ifdef PATSEQ_STEP_TIMESTAMP_EN
    logic        run_exit_c;
    logic [31:0] last_cyc_q, last_cyc_d;

    assign run_exit_c = (state_q == ST_RUN) && !pause && !abort && (pg_done || timeout_hit_c);

    // run_q counts from 0, so the duration is one more (saturating)
    always_comb begin
        last_cyc_d = last_cyc_q;
        if (run_exit_c) begin
            last_cyc_d = (run_q == '1) ? run_q : run_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cyc_q <= '0;
        end else begin
            last_cyc_q <= last_cyc_d;
        end
    end

    assign last_step_cycles = last_cyc_q;
`endif

endmodule
